instruction_fetch: RTL and testbench

Instruction Fetch (IF) stage; sits directly upstream of the decoder and drives its instruction input.
- Keeps the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small prefetch FIFO and presents them to decode with valid/ready.
- Handles branch redirects from Execute/Mem by flushing the FIFO and discarding any in-flight response.

---
 rtl/instruction_fetch_pkg.sv | 27 ++
 rtl/instruction_fetch_fetch_fifo.sv | 65 ++++++
 rtl/instruction_fetch.sv | 135 +++++++++++++
 tb/tb_instruction_fetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared widths, reset vector default, IF state encoding and FIFO entry layout
// for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int WORD_WIDTH  = 32;
  localparam int INSTR_WIDTH = 32;

  localparam logic [WORD_WIDTH-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  // FETCH is normal operation; DISCARD waits out a request made stale by a redirect.
  typedef enum logic {
    FETCH   = 1'b0,
    DISCARD = 1'b1
  } if_state_t;

  // One prefetch buffer entry: the returned word and the address it came from.
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instruction;
    logic [WORD_WIDTH-1:0]  pc;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instruction_fetch_fetch_fifo.sv
// Prefetch buffer: small registered synchronous FIFO with a one-cycle flush.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             in_Clk,
  input  logic             in_Reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     data,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  assign empty = (count == CNT_W'(0));
  assign full  = (count == CNT_W'(DEPTH));
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; flush empties the buffer in one cycle.
  always_ff @(posedge in_Clk or posedge in_Reset) begin
    if (in_Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the fetch PC, runs the single-outstanding
// req/ack read handshake to instruction memory, buffers returned words and
// presents them to decode. Redirects flush the buffer and drop stale data.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          FIFO_DEPTH   = 2
) (
  input  logic                   in_Clk,
  input  logic                   in_Reset,
  output logic                   out_Imem_req,
  output logic [WORD_WIDTH-1:0]  out_Imem_addr,
  input  logic                   in_Imem_ack,
  input  logic [INSTR_WIDTH-1:0] in_Imem_data,
  output logic                   out_Valid,
  output logic [INSTR_WIDTH-1:0] out_Instruction,
  output logic [WORD_WIDTH-1:0]  out_Instr_pc,
  input  logic                   in_Ready,
  input  logic                   in_Branch_taken,
  input  logic [WORD_WIDTH-1:0]  in_Branch_target
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if_state_t             state;
  logic [WORD_WIDTH-1:0] pc;
  logic [WORD_WIDTH-1:0] target;
  logic [WORD_WIDTH-1:0] branch_addr;
  logic [WORD_WIDTH-1:0] fetch_pc;
  logic                  accept;
  logic                  waiting;
  logic                  push;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  empty;
  logic                  full;
  fetch_entry_t          wr_entry;
  fetch_entry_t          head;

  assign branch_addr = align_word(in_Branch_target);
  assign accept      = out_Imem_req && in_Imem_ack;
  assign waiting     = out_Imem_req && !in_Imem_ack;
  // A returned word is kept only in normal operation and only if no redirect lands with it.
  assign push        = accept && (state == FETCH) && !in_Branch_taken && (!full || pop);
  assign pop         = out_Valid && in_Ready;
  // Next word to request: just past the one returning now, otherwise unchanged (wraps mod 2^32).
  assign fetch_pc    = accept ? (out_Imem_addr + 32'd4) : pc;

  assign wr_entry.instruction = in_Imem_data;
  assign wr_entry.pc          = out_Imem_addr;

  assign out_Valid       = !empty;
  assign out_Instruction = head.instruction;
  assign out_Instr_pc    = head.pc;

  // Buffer occupancy after this edge, used to decide whether another request fits.
  always_comb begin
    count_next = count;
    if (in_Branch_taken) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CNT_W'(1);
        2'b01:   count_next = count - CNT_W'(1);
        default: count_next = count;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .in_Clk   (in_Clk),
    .in_Reset (in_Reset),
    .push     (push),
    .pop      (pop),
    .flush    (in_Branch_taken),
    .data     (wr_entry),
    .head     (head),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  // PC / handshake state machine; req and addr are held steady while a request is unacked.
  always_ff @(posedge in_Clk or posedge in_Reset) begin
    if (in_Reset) begin
      state         <= FETCH;
      pc            <= RESET_VECTOR;
      target        <= '0;
      out_Imem_req  <= 1'b0;
      out_Imem_addr <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (in_Branch_taken) begin
            if (waiting) begin
              // Memory still owes a word for the old path; wait it out then go to target.
              state  <= DISCARD;
              target <= branch_addr;
            end else begin
              out_Imem_req  <= 1'b1;
              out_Imem_addr <= branch_addr;
              pc            <= branch_addr;
            end
          end else if (waiting) begin
            state <= FETCH;
          end else begin
            pc            <= fetch_pc;
            out_Imem_req  <= (count_next < CNT_W'(FIFO_DEPTH));
            out_Imem_addr <= fetch_pc;
          end
        end
        DISCARD: begin
          if (in_Branch_taken) begin
            target <= branch_addr;
          end
          if (in_Imem_ack) begin
            state         <= FETCH;
            out_Imem_req  <= 1'b1;
            out_Imem_addr <= in_Branch_taken ? branch_addr : target;
            pc            <= in_Branch_taken ? branch_addr : target;
          end
        end
        default: begin
          state        <= FETCH;
          out_Imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed phases push expected request
// addresses and expected decode-side words; monitors pop and compare on handshakes.
module tb_instruction_fetch;

  localparam int          B   = 3;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        ack = 1'b0;
  logic [31:0] mdata = 32'h0;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] ipc;
  logic        ready = 1'b0;
  logic        br = 1'b0;
  logic [31:0] btgt = 32'h0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int latency = 0;
  int wcnt = 0;
  bit force_ack = 1'b0;

  logic [31:0] exp_req [$];
  logic [31:0] exp_out [$];
  logic [31:0] e_req;
  logic [31:0] e_out;

  instruction_fetch #(
    .RESET_VECTOR(32'h0000_0000),
    .FIFO_DEPTH  (2)
  ) dut (
    .in_Clk           (clk),
    .in_Reset         (rst),
    .out_Imem_req     (req),
    .out_Imem_addr    (addr),
    .in_Imem_ack      (ack),
    .in_Imem_data     (mdata),
    .out_Valid        (valid),
    .out_Instruction  (instr),
    .out_Instr_pc     (ipc),
    .in_Ready         (ready),
    .in_Branch_taken  (br),
    .in_Branch_target (btgt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic at_cycle(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory model: acks `latency` cycles after req appears; forced ack models a late response.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (force_ack) begin
        ack   = 1'b1;
        mdata = 32'hDEAD_BEEF;
        wcnt  = 0;
      end else if (req === 1'b1) begin
        if (wcnt >= latency) begin
          ack   = 1'b1;
          mdata = word_at(addr);
          wcnt  = 0;
        end else begin
          ack  = 1'b0;
          wcnt = wcnt + 1;
        end
      end else begin
        ack  = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Request monitor: every accepted request must be the next expected address.
  always @(negedge clk) begin
    if (req === 1'b1 && ack === 1'b1) begin
      if (exp_req.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL req_unexpected: got addr %h expected none", addr);
      end else begin
        e_req = exp_req.pop_front();
        check("req_addr", addr, e_req);
      end
    end
  end

  // Decode-side monitor: every consumed word must be the next expected pc and its data.
  always @(negedge clk) begin
    if (valid === 1'b1 && ready === 1'b1) begin
      if (exp_out.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_unexpected: got pc %h expected none", ipc);
      end else begin
        e_out = exp_out.pop_front();
        check("out_pc", ipc, e_out);
        check("out_instr", instr, word_at(e_out));
      end
    end
  end

  initial begin
    // Phase 1/2: zero-wait memory, stall fills the buffer, then resume.
    for (int i = 0; i < 11; i++) exp_req.push_back(32'(i * 4));
    for (int i = 0; i < 9; i++)  exp_out.push_back(32'(i * 4));
    #2 rst = 1'b1;
    at_cycle(2);
    @(negedge clk);
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", addr, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_ipc", ipc, 32'd0);

    at_cycle(B);
    rst = 1'b0;
    ready = 1'b1;
    at_cycle(B + 1);
    @(negedge clk);
    check("first_valid", {31'd0, valid}, 32'd0);
    check("first_req", {31'd0, req}, 32'd1);
    check("first_addr", addr, 32'h0000_0000);
    at_cycle(B + 2);
    @(negedge clk);
    check("valid_rise", {31'd0, valid}, 32'd1);
    at_cycle(B + 7);
    ready = 1'b0;
    at_cycle(B + 9);
    @(negedge clk);
    check("full_req_low", {31'd0, req}, 32'd0);
    check("full_valid", {31'd0, valid}, 32'd1);
    check("full_head_pc", ipc, 32'h0000_0014);
    at_cycle(B + 10);
    ready = 1'b1;
    at_cycle(B + 14);
    ready = 1'b0;

    // Phase 3: slow memory, unaligned redirect, redirect into DISCARD, latest target wins.
    at_cycle(B + 16);
    latency = 3;
    exp_req.push_back(32'h0000_0200);
    exp_req.push_back(32'h0000_0204);
    exp_req.push_back(32'h0000_0100);
    exp_req.push_back(32'h0000_0104);
    exp_req.push_back(32'h0000_0108);
    exp_out.push_back(32'h0000_0200);
    exp_out.push_back(32'h0000_0100);
    at_cycle(B + 17);
    br = 1'b1;
    btgt = 32'h0000_0203;
    at_cycle(B + 18);
    br = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("redir_align_addr", addr, 32'h0000_0200);
    check("redir_flush_valid", {31'd0, valid}, 32'd0);
    at_cycle(B + 23);
    br = 1'b1;
    btgt = 32'h0000_0300;
    at_cycle(B + 24);
    btgt = 32'h0000_0100;
    @(negedge clk);
    check("discard_req_hold", {31'd0, req}, 32'd1);
    check("discard_addr_hold", addr, 32'h0000_0204);
    check("discard_valid", {31'd0, valid}, 32'd0);
    at_cycle(B + 25);
    br = 1'b0;
    at_cycle(B + 26);
    @(negedge clk);
    check("discard_target_req", {31'd0, req}, 32'd1);
    check("discard_target_addr", addr, 32'h0000_0100);
    at_cycle(B + 31);
    ready = 1'b0;

    // Phase 4: redirect together with ack and pop; target wraps the address space.
    at_cycle(B + 39);
    latency = 0;
    exp_req.push_back(32'h0000_010C);
    exp_req.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) exp_req.push_back(32'(i * 4));
    exp_out.push_back(32'h0000_0104);
    exp_out.push_back(32'h0000_0108);
    exp_out.push_back(32'hFFFF_FFFC);
    for (int i = 0; i < 3; i++) exp_out.push_back(32'(i * 4));
    @(negedge clk);
    check("quiet_req_low", {31'd0, req}, 32'd0);
    at_cycle(B + 40);
    ready = 1'b1;
    at_cycle(B + 41);
    br = 1'b1;
    btgt = 32'hFFFF_FFFF;
    at_cycle(B + 42);
    br = 1'b0;
    @(negedge clk);
    check("ack_redir_valid", {31'd0, valid}, 32'd0);
    check("ack_redir_addr", addr, 32'hFFFF_FFFC);
    at_cycle(B + 43);
    @(negedge clk);
    check("wrap_addr", addr, 32'h0000_0000);
    at_cycle(B + 47);
    ready = 1'b0;

    // Phase 5: reset while a request is pending, with memory acking during reset.
    at_cycle(B + 48);
    latency = 3;
    at_cycle(B + 49);
    br = 1'b1;
    btgt = 32'h0000_0400;
    at_cycle(B + 50);
    br = 1'b0;
    @(negedge clk);
    check("pending_req", {31'd0, req}, 32'd1);
    check("pending_addr", addr, 32'h0000_0400);
    at_cycle(B + 51);
    rst = 1'b1;
    force_ack = 1'b1;
    at_cycle(B + 52);
    @(negedge clk);
    check("midrst_req", {31'd0, req}, 32'd0);
    check("midrst_addr", addr, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_instr", instr, 32'd0);
    check("midrst_ipc", ipc, 32'd0);
    at_cycle(B + 53);
    force_ack = 1'b0;
    latency = 0;
    for (int i = 0; i < 7; i++) exp_req.push_back(32'(i * 4));
    for (int i = 0; i < 5; i++) exp_out.push_back(32'(i * 4));
    at_cycle(B + 54);
    rst = 1'b0;
    ready = 1'b1;
    at_cycle(B + 55);
    @(negedge clk);
    check("postrst_req", {31'd0, req}, 32'd1);
    check("postrst_addr", addr, 32'h0000_0000);
    check("postrst_valid", {31'd0, valid}, 32'd0);
    at_cycle(B + 61);
    ready = 1'b0;

    at_cycle(B + 64);
    @(negedge clk);
    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("out_queue_drained", 32'(exp_out.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
